// File: rtl/jpeg_stream_arbiter.sv
// Round-robin, whole-image arbiter that shares one word-stream JPEG decoder
// between NUM_SRC sources; the grant is held until frame done or drain timeout.
module jpeg_stream_arbiter #(
   parameter int NUM_SRC       = 4,
   parameter int SRC_W         = $clog2(NUM_SRC),
   parameter int DRAIN_TIMEOUT = 65535
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_SRC*32-1:0] src_data,
   input  logic [NUM_SRC-1:0]   src_valid,
   output logic [NUM_SRC-1:0]   src_stall,
   output logic [31:0]          dec_data,
   output logic                 dec_valid,
   input  logic                 dec_stall,
   input  logic                 dec_frame_done,
   output logic [SRC_W-1:0]     grant_id,
   output logic                 busy,
   output logic                 timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HEADER,
      ST_PAYLOAD,
      ST_DRAIN
   } state_t;

   localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_TIMEOUT - 1);

   state_t           state_reg, state_next;
   logic [SRC_W-1:0] grant_reg, grant_next;
   logic [SRC_W-1:0] rr_ptr_reg, rr_ptr_next;
   logic [31:0]      byte_cnt_reg, byte_cnt_next;
   logic [31:0]      drain_cnt_reg, drain_cnt_next;
   logic             timeout_reg, timeout_next;

   logic [31:0]      src_word [NUM_SRC];
   logic [SRC_W-1:0] pick;
   logic [SRC_W-1:0] grant_inc;
   logic             any_req;
   logic             streaming;
   logic             xfer;

   function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NUM_SRC) sum = sum - NUM_SRC;
      return SRC_W'(sum);
   endfunction

   assign streaming = (state_reg == ST_HEADER) || (state_reg == ST_PAYLOAD);

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         assign src_word[gi]  = src_data[32*gi +: 32];
         // Only the granted source sees the decoder's stall; everyone else waits.
         assign src_stall[gi] = (streaming && (grant_reg == SRC_W'(gi))) ? dec_stall : 1'b1;
      end
   endgenerate

   assign dec_data    = src_word[grant_reg];
   assign dec_valid   = streaming && src_valid[grant_reg];
   assign xfer        = dec_valid && !dec_stall;
   assign any_req     = |src_valid;
   assign grant_inc   = (grant_reg == SRC_W'(NUM_SRC - 1)) ? '0 : grant_reg + SRC_W'(1);
   assign grant_id    = grant_reg;
   assign busy        = (state_reg != ST_IDLE);
   assign timeout_err = timeout_reg;

   // Scan from the far end back towards rr_ptr so the nearest requester wins.
   always_comb begin
      pick = rr_ptr_reg;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (src_valid[wrap_add(rr_ptr_reg, k)]) pick = wrap_add(rr_ptr_reg, k);
      end
   end

   always_comb begin
      state_next     = state_reg;
      grant_next     = grant_reg;
      rr_ptr_next    = rr_ptr_reg;
      byte_cnt_next  = byte_cnt_reg;
      drain_cnt_next = drain_cnt_reg;
      timeout_next   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (any_req) begin
               grant_next = pick;
               state_next = ST_HEADER;
            end
         end
         ST_HEADER: begin
            if (xfer) begin
               byte_cnt_next = dec_data;
               // A zero-length header aborts the image without waiting for the decoder.
               if (dec_data == 32'd0) begin
                  state_next  = ST_IDLE;
                  rr_ptr_next = grant_inc;
               end else begin
                  state_next = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            if (xfer) begin
               byte_cnt_next = (byte_cnt_reg >= 32'd4) ? byte_cnt_reg - 32'd4 : 32'd0;
               if (byte_cnt_reg <= 32'd4) begin
                  state_next     = ST_DRAIN;
                  drain_cnt_next = 32'd0;
               end
            end
         end
         ST_DRAIN: begin
            drain_cnt_next = drain_cnt_reg + 32'd1;
            if (dec_frame_done) begin
               state_next  = ST_IDLE;
               rr_ptr_next = grant_inc;
            end else if (drain_cnt_reg == DRAIN_LAST) begin
               timeout_next = 1'b1;
               state_next   = ST_IDLE;
               rr_ptr_next  = grant_inc;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         grant_reg     <= '0;
         rr_ptr_reg    <= '0;
         byte_cnt_reg  <= '0;
         drain_cnt_reg <= '0;
         timeout_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         grant_reg     <= grant_next;
         rr_ptr_reg    <= rr_ptr_next;
         byte_cnt_reg  <= byte_cnt_next;
         drain_cnt_reg <= drain_cnt_next;
         timeout_reg   <= timeout_next;
      end
   end

endmodule

// File: tb/tb_jpeg_stream_arbiter.sv
// Bench for jpeg_stream_arbiter: word-queue source models, an image-level
// reference model checked every cycle, and directed scenarios with literal checks.
module tb_jpeg_stream_arbiter;
   localparam int N   = 4;
   localparam int SW  = 2;
   localparam int TMO = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [N*32-1:0] src_data = '0;
   logic [N-1:0]  src_valid = '0;
   logic [N-1:0]  src_stall;
   logic [31:0]   dec_data;
   logic          dec_valid;
   logic          dec_stall = 1'b0;
   logic          dec_frame_done = 1'b0;
   logic [SW-1:0] grant_id;
   logic          busy;
   logic          timeout_err;

   always #5 clock = ~clock;

   jpeg_stream_arbiter #(.NUM_SRC(N), .DRAIN_TIMEOUT(TMO)) dut (
      .clock          (clock),
      .reset          (reset),
      .src_data       (src_data),
      .src_valid      (src_valid),
      .src_stall      (src_stall),
      .dec_data       (dec_data),
      .dec_valid      (dec_valid),
      .dec_stall      (dec_stall),
      .dec_frame_done (dec_frame_done),
      .grant_id       (grant_id),
      .busy           (busy),
      .timeout_err    (timeout_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Per-source word queues (head/tail into a fixed store).
   logic [31:0] mem [N][64];
   int  head [N];
   int  tail [N];
   bit  cons [N];
   bit  flush = 0, auto_done = 0, manual_done = 0;

   // Image-level model: mode 0 idle, 1 waiting for header, 2 payload, 3 drain.
   int     mode_m = 0, gid_m = 0, rr_m = 0, age_m = 0;
   longint words_left_m = 0;
   bit     tmo_m = 0, model_on = 0;

   int n_grants = 0, n_dv = 0, n_xfer = 0, n_stalled = 0, n_busy = 0, n_tmo = 0;
   int glog [64];
   bit busy_prev = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic push(input int s, input logic [31:0] w);
      mem[s][tail[s]] = w;
      tail[s]++;
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         if (flush) head[i] = tail[i];
         else if (cons[i] && head[i] < tail[i]) head[i]++;
         cons[i] = 0;
         src_valid[i] = (head[i] < tail[i]);
         src_data[32*i +: 32] = src_valid[i] ? mem[i][head[i]] : 32'h0;
      end
      dec_frame_done = manual_done || (auto_done && mode_m == 3);
   endtask

   task automatic observe_and_check();
      bit          streaming, exp_dv, xfer;
      logic [31:0] w;
      streaming = (mode_m == 1) || (mode_m == 2);
      exp_dv    = streaming && src_valid[gid_m];
      if (model_on) begin
         check("busy", busy, (mode_m != 0));
         check("grant_id", grant_id, gid_m);
         check("timeout_err", timeout_err, tmo_m);
         check("dec_valid", dec_valid, exp_dv);
         for (int i = 0; i < N; i++)
            check($sformatf("src_stall%0d", i), src_stall[i],
                  (streaming && gid_m == i) ? dec_stall : 1'b1);
         if (exp_dv) check("dec_data", dec_data, mem[gid_m][head[gid_m]]);
      end
      if (busy && !busy_prev) begin
         glog[n_grants] = grant_id;
         n_grants++;
      end
      busy_prev = busy;
      if (busy) n_busy++;
      if (dec_valid) n_dv++;
      if (dec_valid && !dec_stall) n_xfer++;
      if (dec_valid && dec_stall) n_stalled++;
      if (timeout_err) n_tmo++;
      for (int i = 0; i < N; i++) cons[i] = src_valid[i] && !src_stall[i];

      if (reset) begin
         mode_m = 0; gid_m = 0; rr_m = 0; age_m = 0; words_left_m = 0; tmo_m = 0;
         model_on = 1;
      end else if (model_on) begin
         xfer  = exp_dv && !dec_stall;
         tmo_m = 0;
         case (mode_m)
            0: if (src_valid != 0) begin
               for (int k = N - 1; k >= 0; k--)
                  if (src_valid[(rr_m + k) % N]) gid_m = (rr_m + k) % N;
               mode_m = 1;
            end
            1: if (xfer) begin
               w = src_data[32*gid_m +: 32];
               if (w == 0) begin
                  mode_m = 0;
                  rr_m   = (gid_m + 1) % N;
               end else begin
                  words_left_m = (longint'(w) + 3) / 4;
                  mode_m = 2;
               end
            end
            2: if (xfer) begin
               words_left_m--;
               if (words_left_m == 0) begin
                  mode_m = 3;
                  age_m  = 0;
               end
            end
            default: begin
               if (dec_frame_done) begin
                  mode_m = 0;
                  rr_m   = (gid_m + 1) % N;
               end else if (age_m == TMO - 1) begin
                  tmo_m  = 1;
                  mode_m = 0;
                  rr_m   = (gid_m + 1) % N;
               end else begin
                  age_m++;
               end
            end
         endcase
      end
   endtask

   task automatic tick();
      drive_inputs();
      @(negedge clock);
      observe_and_check();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_mode(input int m, input int limit);
      int c = 0;
      while (mode_m != m && c < limit) begin
         tick();
         c++;
      end
      check($sformatf("reach_state%0d_in_budget", m), (c < limit), 1);
   endtask

   task automatic do_reset();
      reset = 1; flush = 1; dec_stall = 0; manual_done = 0; auto_done = 0;
      tick();
      reset = 0; flush = 0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base_dv, base_x, base_s, base_b, base_t, g, cnt;

      repeat (3) tick();
      check("rst_src_stall", src_stall, 4'hF);
      check("rst_busy", busy, 0);
      check("rst_grant", grant_id, 0);
      check("rst_dec_valid", dec_valid, 0);
      check("rst_timeout", timeout_err, 0);
      reset = 0;
      tick();

      // Single image from source 1: header 10, three words.
      base_dv = n_dv;
      push(1, 32'd10); push(1, 32'hA0A0_0001); push(1, 32'hA0A0_0002); push(1, 32'hA0A0_0003);
      tick();
      check("t1_busy", busy, 1);
      check("t1_grant", grant_id, 1);
      check("t1_dec_valid", dec_valid, 1);
      check("t1_header_word", dec_data, 10);
      wait_mode(3, 20);
      check("t1_valid_cycles", n_dv - base_dv, 4);
      manual_done = 1;
      tick();
      manual_done = 0;
      check("t1_busy_after_done", busy, 0);
      tick();

      // Round robin among sources 0, 2, 3.
      do_reset();
      auto_done = 1;
      g = n_grants;
      push(0, 4); push(0, 32'h100); push(0, 4); push(0, 32'h101);
      push(2, 4); push(2, 32'h200);
      push(3, 4); push(3, 32'h300);
      repeat (40) tick();
      check("t2_grant_count", n_grants - g, 4);
      check("t2_grant0", glog[g], 0);
      check("t2_grant1", glog[g+1], 2);
      check("t2_grant2", glog[g+2], 3);
      check("t2_grant3", glog[g+3], 0);

      // Backpressure during payload of a 12-byte image.
      do_reset();
      auto_done = 1;
      base_x = n_xfer; base_s = n_stalled;
      push(1, 12); push(1, 32'hB1); push(1, 32'hB2); push(1, 32'hB3);
      wait_mode(2, 20);
      dec_stall = 1;
      repeat (5) tick();
      dec_stall = 0;
      repeat (10) tick();
      check("t3_stalled_cycles", n_stalled - base_s, 5);
      check("t3_payload_words", n_xfer - base_x - 1, 3);
      check("t3_idle_after", busy, 0);

      // Zero header aborts; next pointer is 3.
      do_reset();
      auto_done = 1;
      base_x = n_xfer; base_b = n_busy;
      push(2, 0);
      repeat (6) tick();
      check("t4_words_forwarded", n_xfer - base_x, 1);
      check("t4_busy_cycles", n_busy - base_b, 1);
      g = n_grants;
      push(0, 4); push(0, 32'hC0);
      push(3, 4); push(3, 32'hC3);
      repeat (20) tick();
      check("t4_next_grant", glog[g], 3);
      check("t4_then_grant", glog[g+1], 0);

      // Drain timeout with no frame-done.
      do_reset();
      base_t = n_tmo;
      push(0, 4); push(0, 32'h55);
      wait_mode(3, 20);
      cnt = 0;
      while (timeout_err !== 1'b1 && cnt < 40) begin
         tick();
         cnt++;
      end
      check("t5_timeout_latency", cnt, 16);
      check("t5_busy_at_timeout", busy, 0);
      tick();
      check("t5_pulse_width", timeout_err, 0);
      check("t5_pulse_count", n_tmo - base_t, 1);

      // Reset while in payload of a 40-byte image.
      do_reset();
      push(1, 40);
      for (int i = 0; i < 10; i++) push(1, 32'hD00 + i);
      wait_mode(2, 20);
      repeat (2) tick();
      reset = 1; flush = 1;
      tick();
      check("t6_src_stall", src_stall, 4'hF);
      check("t6_grant", grant_id, 0);
      check("t6_busy", busy, 0);
      check("t6_dec_valid", dec_valid, 0);
      reset = 0; flush = 0;
      tick();
      auto_done = 1;
      g = n_grants;
      push(2, 4); push(2, 32'hE2);
      repeat (10) tick();
      check("t6_grant_after_reset", glog[g], 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
